// File: rtl/seq_shift_rotate_right.sv
// Multi-cycle shift/rotate unit: logical shift right (SRL) and rotate right (ROR),
// one bit position per cycle under a start/busy/done handshake.
// Optional macro SEQ_SHIFT_ROL_EN adds rotate left (ROL), selected by mode[1].
module seq_shift_rotate_right #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;

`ifdef SEQ_SHIFT_ROL_EN
  logic [1:0] op_q, op_d;
  assign op_d = mode;
`else
  // Only the SRL/ROR select is kept; mode[1] has no effect in this build.
  logic op_q, op_d;
  logic unused_mode_hi;
  assign op_d           = mode[0];
  assign unused_mode_hi = mode[1];
`endif

  // Single-bit step of the selected operation on the working register.
  logic [WIDTH-1:0] step;
  always_comb begin
    step = {1'b0, data_q[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROL_EN
    if (op_q[1]) begin
      step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    end else if (op_q[0]) begin
      step = {data_q[0], data_q[WIDTH-1:1]};
    end
`else
    if (op_q) begin
      step = {data_q[0], data_q[WIDTH-1:1]};
    end
`endif
  end

  // State and datapath registers; synchronous reset has priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      if (state_q == StIdle && start) begin
        op_q <= op_d;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          data_d  = data_in;
          count_d = shamt;
          state_d = (shamt == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        data_d  = step;
        count_d = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no path from start.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    data_out = data_q;
  end

endmodule

// File: tb/tb_seq_shift_rotate_right.sv
// Directed self-checking bench for seq_shift_rotate_right.
module tb_seq_shift_rotate_right;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_rotate_right #(
    .WIDTH  (16),
    .SHAMT_W(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: issue start, scramble operands afterwards, then verify
  // latency, busy duration, result and post-done hold.
  task automatic run_op(input string tag, input logic [15:0] din, input logic [3:0] sh,
                        input logic [1:0] md, input logic [15:0] exp);
    int lat;
    int busy_cycles;
    data_in = din;
    shamt   = sh;
    mode    = md;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = ~din;
    shamt   = ~sh;
    mode    = ~md;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      tick();
      lat++;
    end
    if (busy) busy_cycles++;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(sh) + 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(sh) + 32'd1);
    check({tag, "_data"}, 32'(data_out), 32'(exp));
    tick();
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    int lat;
    int pulses;
    logic [15:0] rol_exp;

    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0;
    shamt   = 4'h0;
    mode    = 2'b00;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();

    run_op("srl4", 16'h8001, 4'd4, 2'b00, 16'h0800);
    run_op("ror1", 16'h8001, 4'd1, 2'b01, 16'hC000);
    run_op("ror15", 16'h1234, 4'd15, 2'b01, 16'h2468);
    run_op("ror0", 16'hBEEF, 4'd0, 2'b01, 16'hBEEF);
    run_op("srl15", 16'h8000, 4'd15, 2'b00, 16'h0001);

    // Start during RUN plus operand changes must be ignored.
    data_in = 16'h00F0;
    shamt   = 4'd8;
    mode    = 2'b00;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 1;
    pulses  = 0;
    tick();
    lat++;
    start   = 1'b1;
    data_in = 16'hFFFF;
    shamt   = 4'd3;
    mode    = 2'b01;
    tick();
    lat++;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("midrun_latency", 32'(lat), 32'd9);
    check("midrun_data", 32'(data_out), 32'h0000);
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      tick();
    end
    check("midrun_pulses", 32'(pulses), 32'd1);

    // Reset mid-operation discards it.
    data_in = 16'h1234;
    shamt   = 4'd10;
    mode    = 2'b01;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("rst_no_activity", 32'(pulses), 32'd0);
    run_op("post_rst", 16'h8001, 4'd1, 2'b01, 16'hC000);

`ifdef SEQ_SHIFT_ROL_EN
    rol_exp = 16'h0018;
`else
    rol_exp = 16'h0800;
`endif
    run_op("mode10", 16'h8001, 4'd4, 2'b10, rol_exp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
